wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (the EXE/WB pipeline register outputs) and a multi-cycle unit (MCU, e.g. divider/load) that completes out of order. Holds one MCU result in a capture register, gives the pipeline priority, and forces an MCU slot with a pipeline stall when the MCU result has waited too long. Sits between the EXE/WB register and the register file.

## Interface
- STARVE_LIMIT, 4: cycles a held MCU result may lose arbitration before it is forced; legal 1..15.
- XLEN, 32: data width.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pipe_we  in  1  pipeline writeback request (EXE/WB regwrite).
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  XLEN  pipeline result (EXE/WB ALU result).
- mcu_valid  in  1  MCU result valid.
- mcu_ready  out  1  capture register can accept; transfer when mcu_valid && mcu_ready.
- mcu_rd  in  5  MCU destination register.
- mcu_data  in  XLEN  MCU result.
- stall_pipe  out  1  combinational; holds the EXE/WB register and upstream this cycle.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  XLEN  register-file write data (registered).

## Operation
- States: EMPTY (capture register empty), HELD (one MCU result held), FORCE (held result wins next grant).
- mcu_ready = (state == EMPTY), or (state != EMPTY and the held entry is granted this cycle); max one MCU transfer per cycle.
- EMPTY: pipe request is granted; on an MCU transfer, capture {rd,data}, wait_cnt <= 0, go HELD. A result captured this cycle is never granted the same cycle.
- HELD: pipe_we=1 → pipe granted, wait_cnt++; when wait_cnt reaches STARVE_LIMIT-1 on a loss, go FORCE. pipe_we=0 → held entry granted; go EMPTY, or stay HELD if a new MCU transfer occurs in the same cycle (wait_cnt <= 0).
- FORCE: held entry granted; stall_pipe=1 iff pipe_we=1; go EMPTY, or HELD if a new transfer occurs.
- stall_pipe is 0 in EMPTY and HELD.
- WAW rule: pipe instruction is younger. If pipe_we=1 and pipe_rd == held rd, the held entry is discarded the same cycle (no write, counts as vacated, mcu_ready=1); pipe granted.
- x0: any grant with rd==0 produces rf_we=0; the grant is still consumed (held entry leaves, state updates).
- Granted {rd,data} registered into rf_waddr/rf_wdata; rf_we=1 for a grant with rd≠0, else 0.

## Timing
- Reset (async): state=EMPTY, wait_cnt=0, capture register cleared, rf_we=0, rf_waddr=0, rf_wdata=0; mcu_ready=1 and stall_pipe=0 immediately after reset deasserts.
- Reset mid-operation discards any held result; no write issued.
- Grant-to-rf_we latency: 1 cycle.
- MCU transfer to earliest write: 2 cycles (capture, then grant in a later cycle, then registered output).
- Worst-case MCU hold: STARVE_LIMIT losing cycles, then FORCE grant; result written by cycle STARVE_LIMIT+2 after transfer.
- stall_pipe depends on state and pipe_we only, no path from mcu_valid.

## Structure
- Shared package (riscv_pkg): state enum wb_arb_state_t {EMPTY, HELD, FORCE}, REG_ADDR_W=5, XLEN.
- One sub-module natural: wb_hold_reg (one-entry capture register with valid, load, clear), instantiated once.
- wait_cnt width $clog2(STARVE_LIMIT+1).

## Test plan
- Reset: assert rst mid-HELD with rd=5 held → rf_we=0, mcu_ready=1, stall_pipe=0, no write to x5 afterward.
- Idle-pipe MCU: mcu_valid rd=7 data=0xDEAD_BEEF, pipe_we=0 → capture cycle N, grant N+1, rf_we=1 rf_waddr=7 rf_wdata=0xDEADBEEF at N+2.
- Starvation: MCU rd=3 held, pipe_we=1 continuously (rd=1..) with STARVE_LIMIT=4 → 4 pipe writes, then one cycle stall_pipe=1 with x3 written next cycle, stall_pipe back to 0.
- WAW: held rd=9 data=0x11, pipe_we=1 rd=9 data=0x22 → only x9=0x22 written, state EMPTY, mcu_ready=1 that cycle.
- x0: pipe_we=1 rd=0, then MCU rd=0 → rf_we stays 0 throughout, MCU entry drained (state EMPTY).
- Back-to-back MCU: pipe_we=0, MCU transfers rd=4 then rd=6 consecutive cycles → writes x4 then x6 on consecutive cycles, mcu_ready never 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared widths and the writeback-arbiter state encoding.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HELD  = 2'd1,
    FORCE = 2'd2
  } wb_arb_state_t;
endpackage

// File: rtl/wb_hold_reg.sv
// One-entry capture register for an MCU result; load takes priority over clear.
module wb_hold_reg
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [REG_ADDR_W-1:0] d_rd,
  input  logic [XLEN-1:0]       d_data,
  output logic                  valid,
  output logic [REG_ADDR_W-1:0] q_rd,
  output logic [XLEN-1:0]       q_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      q_rd   <= '0;
      q_data <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      q_rd   <= d_rd;
      q_data <= d_data;
    end else if (clear) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between in-order writeback and an
// out-of-order multi-cycle unit, with a starvation bound on the MCU result.
module wb_port_arbiter
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = riscv_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  input  logic                  mcu_valid,
  output logic                  mcu_ready,
  input  logic [REG_ADDR_W-1:0] mcu_rd,
  input  logic [XLEN-1:0]       mcu_data,
  output logic                  stall_pipe,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  wb_arb_state_t         state_reg;
  logic [CW-1:0]         wait_cnt_reg;
  logic                  held_valid;
  logic [REG_ADDR_W-1:0] held_rd;
  logic [XLEN-1:0]       held_data;
  logic                  grant_pipe;
  logic                  grant_held;
  logic                  vacate;
  logic                  xfer;

  wb_hold_reg #(.XLEN(XLEN)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load   (xfer),
    .clear  (vacate),
    .d_rd   (mcu_rd),
    .d_data (mcu_data),
    .valid  (held_valid),
    .q_rd   (held_rd),
    .q_data (held_data)
  );

  // In FORCE the pipe is stalled rather than discarding the held entry on a
  // matching rd: the stalled pipe write lands a cycle later and still wins.
  always_comb begin
    grant_pipe = 1'b0;
    grant_held = 1'b0;
    vacate     = 1'b0;
    stall_pipe = 1'b0;
    case (state_reg)
      EMPTY: grant_pipe = pipe_we;
      HELD: begin
        if (pipe_we) begin
          grant_pipe = 1'b1;
          vacate     = held_valid && (pipe_rd == held_rd);
        end else begin
          grant_held = 1'b1;
          vacate     = 1'b1;
        end
      end
      FORCE: begin
        grant_held = 1'b1;
        vacate     = 1'b1;
        stall_pipe = pipe_we;
      end
      default: ;
    endcase
    mcu_ready = (state_reg == EMPTY) || vacate;
    xfer      = mcu_valid && mcu_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= EMPTY;
      wait_cnt_reg <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
    end else begin
      if (xfer) begin
        state_reg    <= HELD;
        wait_cnt_reg <= '0;
      end else if (vacate) begin
        state_reg    <= EMPTY;
      end else if (state_reg == HELD && pipe_we) begin
        if (wait_cnt_reg == CW'(STARVE_LIMIT - 1)) state_reg <= FORCE;
        else wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end

      rf_we <= (grant_pipe && pipe_rd != '0) || (grant_held && held_rd != '0);
      if (grant_pipe) begin
        rf_waddr <= pipe_rd;
        rf_wdata <= pipe_data;
      end else if (grant_held) begin
        rf_waddr <= held_rd;
        rf_wdata <= held_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios plus random traffic.
module tb_wb_port_arbiter;
  import riscv_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        mcu_valid = 1'b0;
  logic        mcu_ready;
  logic [4:0]  mcu_rd = '0;
  logic [31:0] mcu_data = '0;
  logic        stall_pipe;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mcu_valid(mcu_valid), .mcu_ready(mcu_ready), .mcu_rd(mcu_rd), .mcu_data(mcu_data),
    .stall_pipe(stall_pipe), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic ready; logic stall; } cb_t;

  wr_t wr_q[$];
  cb_t cb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  in_reset = 1'b1;

  // Reference model: the held MCU result and how many grants it has lost.
  bit          m_have = 1'b0;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          m_losses;
  bit          last_stall = 1'b0;
  bit          last_ready = 1'b1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(bit pw, logic [4:0] prd, logic [31:0] pd,
                       bit mv, logic [4:0] mrd, logic [31:0] md);
    wr_t w;
    cb_t c;
    bit  vac;
    @(posedge clk);
    #1;
    pipe_we = pw; pipe_rd = prd; pipe_data = pd;
    mcu_valid = mv; mcu_rd = mrd; mcu_data = md;
    w.we = 1'b0; w.a = '0; w.d = '0;
    c.ready = 1'b1; c.stall = 1'b0;
    vac = 1'b0;
    if (!m_have) begin
      if (pw) begin w.we = (prd != 0); w.a = prd; w.d = pd; end
    end else if (m_losses >= LIMIT) begin
      c.stall = pw; vac = 1'b1;
      w.we = (m_rd != 0); w.a = m_rd; w.d = m_data;
    end else if (pw) begin
      w.we = (prd != 0); w.a = prd; w.d = pd;
      if (prd == m_rd) vac = 1'b1;
      else begin m_losses++; c.ready = 1'b0; end
    end else begin
      vac = 1'b1;
      w.we = (m_rd != 0); w.a = m_rd; w.d = m_data;
    end
    if (vac) m_have = 1'b0;
    if (mv && c.ready) begin
      m_have = 1'b1; m_rd = mrd; m_data = md; m_losses = 0;
    end
    last_stall = c.stall;
    last_ready = c.ready;
    $display("cyc pipe(we=%0d rd=%0d) mcu(v=%0d rd=%0d) -> ready=%0d stall=%0d write(we=%0d rd=%0d data=%h)",
             pw, prd, mv, mrd, c.ready, c.stall, w.we, w.a, w.d);
    cb_q.push_back(c);
    wr_q.push_back(w);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: combinational outputs belong to the current cycle, registered
  // write outputs to the transaction issued one cycle earlier.
  initial begin
    cb_t c;
    wr_t w;
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        if (cb_q.size() > 0) begin
          c = cb_q.pop_front();
          chk("mcu_ready", 32'(mcu_ready), 32'(c.ready));
          chk("stall_pipe", 32'(stall_pipe), 32'(c.stall));
        end
        if (wr_q.size() >= 2) begin
          w = wr_q.pop_front();
          chk("rf_we", 32'(rf_we), 32'(w.we));
          if (w.we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(w.a));
            chk("rf_wdata", rf_wdata, w.d);
          end
        end
      end
    end
  end

  initial begin
    logic [4:0]  starve_rd [7];
    bit          pw, mv;
    logic [4:0]  prd, mrd;
    logic [31:0] pd, md;

    repeat (2) @(posedge clk);
    #1;
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset rf_waddr", 32'(rf_waddr), 32'd0);
    chk("reset rf_wdata", rf_wdata, 32'd0);
    chk("reset mcu_ready", 32'(mcu_ready), 32'd1);
    chk("reset stall_pipe", 32'(stall_pipe), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_reset = 1'b0;

    // Idle-pipe MCU result
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    idle(3);

    // Starvation: rd=3 held while the pipe keeps writing
    starve_rd = '{5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd8, 5'd8};
    for (int i = 0; i < 7; i++)
      cycle(1'b1, starve_rd[i], 32'h100 + 32'(i), i == 0, 5'd3, 32'h0000_0033);
    idle(2);

    // WAW: pipe write to the held rd discards the held entry
    cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h11);
    cycle(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0);
    idle(3);

    // x0 from both sources
    cycle(1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
    idle(3);

    // Back-to-back MCU transfers
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'hAAAA_0004);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hBBBB_0006);
    idle(3);

    // Reset while rd=5 is held
    cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd5, 32'h55);
    cycle(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #1;
    in_reset = 1'b1;
    rst = 1'b1;
    #1;
    chk("midreset rf_we", 32'(rf_we), 32'd0);
    chk("midreset mcu_ready", 32'(mcu_ready), 32'd1);
    chk("midreset stall_pipe", 32'(stall_pipe), 32'd0);
    cb_q.delete();
    wr_q.delete();
    m_have = 1'b0;
    last_stall = 1'b0;
    last_ready = 1'b1;
    pipe_we = 1'b0;
    mcu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postreset mcu_ready", 32'(mcu_ready), 32'd1);
    chk("postreset stall_pipe", 32'(stall_pipe), 32'd0);
    in_reset = 1'b0;
    idle(4);

    // Random traffic; stalled pipe and unaccepted MCU requests are held
    pw = 1'b0; prd = '0; pd = '0; mv = 1'b0; mrd = '0; md = '0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        pw  = ($urandom_range(0, 99) < ((i < 300) ? 85 : 30));
        prd = 5'($urandom_range(0, 15));
        pd  = $urandom;
      end
      if (!(mv && !last_ready)) begin
        mv  = ($urandom_range(0, 2) == 0);
        mrd = 5'($urandom_range(0, 15));
        md  = $urandom;
      end
      cycle(pw, prd, pd, mv, mrd, md);
    end
    idle(LIMIT + 4);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
